// File: rtl/spif_reg_bank_gen.sv
// Configuration/diagnostic register bank for the SpiNNaker event I/O path, shared by an APB
// slave (wait states, byte strobes, error response) and the packet receiver.
module spif_reg_bank_gen #(
    parameter int          NUM_PIPES = 4,
    parameter int          NUM_MFLD  = 4,
    parameter int          NUM_RREGS = 16,
    parameter int          NUM_CREGS = 8,
    parameter int          CTR_BITS  = 32,
    parameter int          CTR_SAT   = 1,
    parameter int          RRTE_BITS = 3,
    parameter int          MSFT_BITS = 6,
    parameter logic [31:0] BAD_REG   = 32'hdead_beef
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    apb_psel_in,
    input  logic                                    apb_penable_in,
    input  logic                                    apb_pwrite_in,
    input  logic [9:0]                              apb_paddr_in,
    input  logic [31:0]                             apb_pwdata_in,
    input  logic [3:0]                              apb_pstrb_in,
    output logic [31:0]                             apb_prdata_out,
    output logic                                    apb_pready_out,
    output logic                                    apb_pslverr_out,
    input  logic [7:0]                              prx_addr_in,
    input  logic [31:0]                             prx_wdata_in,
    input  logic                                    prx_wr_in,
    input  logic                                    prx_rd_in,
    output logic [31:0]                             prx_rdata_out,
    output logic                                    prx_rvld_out,
    input  logic [NUM_CREGS-1:0]                    ctr_cnt_in,
    input  logic [31:0]                             status_in,
    input  logic [31:0]                             hw_version_in,
    output logic                                    hssl_stop_out,
    output logic [31:0]                             reply_key_out,
    output logic [31:0]                             input_wait_out,
    output logic [31:0]                             output_wait_out,
    output logic [32*NUM_RREGS-1:0]                 rt_key_out,
    output logic [32*NUM_RREGS-1:0]                 rt_mask_out,
    output logic [RRTE_BITS*NUM_RREGS-1:0]          rt_route_out,
    output logic [32*NUM_PIPES-1:0]                 mp_key_out,
    output logic [32*NUM_PIPES*NUM_MFLD-1:0]        mp_fmsk_out,
    output logic [MSFT_BITS*NUM_PIPES*NUM_MFLD-1:0] mp_fsft_out,
    output logic [CTR_BITS*NUM_CREGS-1:0]           ctr_out
);
    localparam int NUM_MREGS = NUM_PIPES * NUM_MFLD;
    localparam int RR_W = (NUM_RREGS > 1) ? $clog2(NUM_RREGS) : 1;
    localparam int CR_W = (NUM_CREGS > 1) ? $clog2(NUM_CREGS) : 1;
    localparam int PK_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam int MR_W = (NUM_MREGS > 1) ? $clog2(NUM_MREGS) : 1;
    localparam logic [4:0] N_RR = 5'(NUM_RREGS);
    localparam logic [4:0] N_CR = 5'(NUM_CREGS);
    localparam logic [4:0] N_PK = 5'(NUM_PIPES);
    localparam logic [4:0] N_MR = 5'(NUM_MREGS);
    localparam logic [3:0] SEC_CTRL = 4'd0, SEC_RKEY = 4'd1, SEC_RMSK = 4'd2, SEC_RRTE = 4'd3;
    localparam logic [3:0] SEC_CTR  = 4'd4, SEC_MKEY = 4'd5, SEC_MMSK = 4'd6, SEC_MSFT = 4'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} apb_state_t;

    apb_state_t          r_state;
    logic [3:0]          r_sec, r_reg, r_strb;
    logic [31:0]         r_wdata;
    logic                r_write;
    logic [1:0]          r_cfg;
    logic [31:0]         r_resv, r_reply_key, r_in_wait, r_out_wait;
    logic [31:0]         r_rt_key  [NUM_RREGS];
    logic [31:0]         r_rt_mask [NUM_RREGS];
    logic [RRTE_BITS-1:0] r_rt_route [NUM_RREGS];
    logic [31:0]         r_mp_key  [NUM_PIPES];
    logic [31:0]         r_mp_fmsk [NUM_MREGS];
    logic [MSFT_BITS-1:0] r_mp_fsft [NUM_MREGS];
    logic [CTR_BITS-1:0] r_ctr     [NUM_CREGS];

    logic [32:0] w_apb_rd, w_prx_rd;
    logic        w_apb_go, w_apb_err, w_apb_wr, w_ctr_clr, w_prx_wr_ok, w_wr_en;
    logic [31:0] w_apb_merged, w_wr_data;
    logic [3:0]  w_wr_sec, w_wr_idx;
    logic        w_unused;

    function automatic logic is_ro(input logic [3:0] sec, input logic [3:0] idx);
        return (sec == SEC_CTRL) && (idx[3:1] == 3'b111);
    endfunction

    // Bit 32 of the result flags an unmapped section or an index beyond the table.
    function automatic logic [32:0] rd_word(input logic [3:0] sec, input logic [3:0] idx);
        logic [32:0] v;
        v = {1'b1, BAD_REG};
        case (sec)
            SEC_CTRL: begin
                case (idx)
                    4'd0:    v = {1'b0, 30'h0, r_cfg};
                    4'd1:    v = {1'b0, r_resv};
                    4'd2:    v = {1'b0, r_reply_key};
                    4'd3:    v = {1'b0, r_in_wait};
                    4'd4:    v = {1'b0, r_out_wait};
                    4'd14:   v = {1'b0, status_in};
                    4'd15:   v = {1'b0, hw_version_in};
                    default: v = {1'b1, BAD_REG};
                endcase
            end
            SEC_RKEY: if ({1'b0, idx} < N_RR) v = {1'b0, r_rt_key[idx[RR_W-1:0]]};
                      else v = {1'b1, BAD_REG};
            SEC_RMSK: if ({1'b0, idx} < N_RR) v = {1'b0, r_rt_mask[idx[RR_W-1:0]]};
                      else v = {1'b1, BAD_REG};
            SEC_RRTE: if ({1'b0, idx} < N_RR) v = {1'b0, 32'(r_rt_route[idx[RR_W-1:0]])};
                      else v = {1'b1, BAD_REG};
            SEC_CTR:  if ({1'b0, idx} < N_CR) v = {1'b0, 32'(r_ctr[idx[CR_W-1:0]])};
                      else v = {1'b1, BAD_REG};
            SEC_MKEY: if ({1'b0, idx} < N_PK) v = {1'b0, r_mp_key[idx[PK_W-1:0]]};
                      else v = {1'b1, BAD_REG};
            SEC_MMSK: if ({1'b0, idx} < N_MR) v = {1'b0, r_mp_fmsk[idx[MR_W-1:0]]};
                      else v = {1'b1, BAD_REG};
            SEC_MSFT: if ({1'b0, idx} < N_MR) v = {1'b0, 32'(signed'(r_mp_fsft[idx[MR_W-1:0]]))};
                      else v = {1'b1, BAD_REG};
            default:  v = {1'b1, BAD_REG};
        endcase
        return v;
    endfunction

    // Packet writes take the shared write port outright; APB only accesses when it is free.
    always_comb begin
        w_apb_rd     = rd_word(r_sec, r_reg);
        w_prx_rd     = rd_word(prx_addr_in[7:4], prx_addr_in[3:0]);
        w_apb_go     = (r_state == ST_WAIT) && !prx_wr_in;
        w_apb_err    = w_apb_rd[32] || (r_write && is_ro(r_sec, r_reg));
        w_apb_wr     = w_apb_go && r_write && !w_apb_err;
        w_ctr_clr    = w_apb_go && !r_write && !w_apb_err && r_cfg[1] && (r_sec == SEC_CTR);
        w_prx_wr_ok  = prx_wr_in && !w_prx_rd[32] && !is_ro(prx_addr_in[7:4], prx_addr_in[3:0]);
        w_apb_merged = 32'h0;
        for (int b = 0; b < 4; b++) begin
            w_apb_merged[8*b +: 8] = r_strb[b] ? r_wdata[8*b +: 8] : w_apb_rd[8*b +: 8];
        end
        if (prx_wr_in) begin
            w_wr_en   = w_prx_wr_ok;
            w_wr_sec  = prx_addr_in[7:4];
            w_wr_idx  = prx_addr_in[3:0];
            w_wr_data = prx_wdata_in;
        end else begin
            w_wr_en   = w_apb_wr;
            w_wr_sec  = r_sec;
            w_wr_idx  = r_reg;
            w_wr_data = w_apb_merged;
        end
    end

    assign w_unused = ^apb_paddr_in[1:0];

    // APB slave FSM with registered ready/error/read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_sec           <= 4'h0;
            r_reg           <= 4'h0;
            r_strb          <= 4'h0;
            r_wdata         <= 32'h0;
            r_write         <= 1'b0;
            apb_pready_out  <= 1'b0;
            apb_pslverr_out <= 1'b0;
            apb_prdata_out  <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    apb_pready_out <= 1'b0;
                    if (apb_psel_in && !apb_penable_in) begin
                        r_sec   <= apb_paddr_in[9:6];
                        r_reg   <= apb_paddr_in[5:2];
                        r_strb  <= apb_pstrb_in;
                        r_wdata <= apb_pwdata_in;
                        r_write <= apb_pwrite_in;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!prx_wr_in) begin
                        apb_pready_out  <= 1'b1;
                        apb_pslverr_out <= w_apb_err;
                        apb_prdata_out  <= w_apb_rd[31:0];
                        r_state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    apb_pready_out  <= 1'b0;
                    apb_pslverr_out <= 1'b0;
                    r_state         <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Control section registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg       <= 2'b00;
            r_resv      <= BAD_REG;
            r_reply_key <= 32'hffff_fd00;
            r_in_wait   <= 32'd32;
            r_out_wait  <= 32'd32;
        end else if (w_wr_en && (w_wr_sec == SEC_CTRL)) begin
            case (w_wr_idx)
                4'd0:    r_cfg       <= w_wr_data[1:0];
                4'd1:    r_resv      <= w_wr_data;
                4'd2:    r_reply_key <= w_wr_data;
                4'd3:    r_in_wait   <= w_wr_data;
                4'd4:    r_out_wait  <= w_wr_data;
                default: r_cfg       <= r_cfg;
            endcase
        end
    end

    // Router and mapper tables; narrow fields keep the low bits of the written word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_RREGS; i++) begin
                r_rt_key[i]   <= 32'hffff_ffff;
                r_rt_mask[i]  <= 32'h0;
                r_rt_route[i] <= {RRTE_BITS{1'b0}};
            end
            for (int i = 0; i < NUM_PIPES; i++) r_mp_key[i] <= 32'h0;
            for (int i = 0; i < NUM_MREGS; i++) begin
                r_mp_fmsk[i] <= 32'h0;
                r_mp_fsft[i] <= {MSFT_BITS{1'b0}};
            end
        end else if (w_wr_en) begin
            case (w_wr_sec)
                SEC_RKEY: r_rt_key[w_wr_idx[RR_W-1:0]]   <= w_wr_data;
                SEC_RMSK: r_rt_mask[w_wr_idx[RR_W-1:0]]  <= w_wr_data;
                SEC_RRTE: r_rt_route[w_wr_idx[RR_W-1:0]] <= w_wr_data[RRTE_BITS-1:0];
                SEC_MKEY: r_mp_key[w_wr_idx[PK_W-1:0]]   <= w_wr_data;
                SEC_MMSK: r_mp_fmsk[w_wr_idx[MR_W-1:0]]  <= w_wr_data;
                SEC_MSFT: r_mp_fsft[w_wr_idx[MR_W-1:0]]  <= w_wr_data[MSFT_BITS-1:0];
                default:  ;
            endcase
        end
    end

    // Diagnostic counters: write beats clear-on-read, which beats increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CREGS; i++) r_ctr[i] <= {CTR_BITS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CREGS; i++) begin
                if (w_wr_en && (w_wr_sec == SEC_CTR) && (w_wr_idx == 4'(i))) begin
                    r_ctr[i] <= w_wr_data[CTR_BITS-1:0];
                end else if (w_ctr_clr && (r_reg == 4'(i))) begin
                    r_ctr[i] <= {CTR_BITS{1'b0}};
                end else if (ctr_cnt_in[i] && !((CTR_SAT != 0) && (&r_ctr[i]))) begin
                    r_ctr[i] <= r_ctr[i] + CTR_BITS'(1);
                end
            end
        end
    end

    // Packet read port; a read coinciding with a write is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            prx_rvld_out  <= 1'b0;
            prx_rdata_out <= 32'h0;
        end else begin
            prx_rvld_out <= prx_rd_in && !prx_wr_in;
            if (prx_rd_in && !prx_wr_in) prx_rdata_out <= w_prx_rd[31:0];
        end
    end

    assign hssl_stop_out   = r_cfg[0];
    assign reply_key_out   = r_reply_key;
    assign input_wait_out  = r_in_wait;
    assign output_wait_out = r_out_wait;

    for (genvar g = 0; g < NUM_RREGS; g++) begin : g_rt
        assign rt_key_out[32*g +: 32]               = r_rt_key[g];
        assign rt_mask_out[32*g +: 32]              = r_rt_mask[g];
        assign rt_route_out[RRTE_BITS*g +: RRTE_BITS] = r_rt_route[g];
    end
    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_mk
        assign mp_key_out[32*g +: 32] = r_mp_key[g];
    end
    for (genvar g = 0; g < NUM_MREGS; g++) begin : g_mf
        assign mp_fmsk_out[32*g +: 32]               = r_mp_fmsk[g];
        assign mp_fsft_out[MSFT_BITS*g +: MSFT_BITS] = r_mp_fsft[g];
    end
    for (genvar g = 0; g < NUM_CREGS; g++) begin : g_ct
        assign ctr_out[CTR_BITS*g +: CTR_BITS] = r_ctr[g];
    end
endmodule

// File: tb/tb_spif_reg_bank_gen.sv
// Scoreboard bench for spif_reg_bank_gen: directed cases plus randomized APB/packet traffic
// checked against a word-per-location model of the register map.
module tb_spif_reg_bank_gen;
    localparam int          NR     = 4;
    localparam logic [31:0] BAD    = 32'hdead_beef;
    localparam logic [31:0] STATUS = 32'h5a5a_0f0f;
    localparam logic [31:0] HWVER  = 32'h0102_0304;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [9:0]    paddr = 10'h0;
    logic [31:0]   pwdata = 32'h0;
    logic [3:0]    pstrb = 4'h0;
    logic [31:0]   prdata;
    logic          pready, pslverr;
    logic [7:0]    prx_addr = 8'h0;
    logic [31:0]   prx_wdata = 32'h0;
    logic          prx_wr = 1'b0, prx_rd = 1'b0;
    logic [31:0]   prx_rdata;
    logic          prx_rvld;
    logic [7:0]    ctr_cnt = 8'h0;
    logic          hssl_stop;
    logic [31:0]   reply_key, in_wait, out_wait;
    logic [32*NR-1:0] rt_key, rt_mask;
    logic [3*NR-1:0]  rt_route;
    logic [127:0]  mp_key;
    logic [511:0]  mp_fmsk;
    logic [95:0]   mp_fsft;
    logic [255:0]  ctr_o;

    spif_reg_bank_gen #(.NUM_RREGS(NR)) dut (
        .clk(clk), .reset(reset),
        .apb_psel_in(psel), .apb_penable_in(penable), .apb_pwrite_in(pwrite),
        .apb_paddr_in(paddr), .apb_pwdata_in(pwdata), .apb_pstrb_in(pstrb),
        .apb_prdata_out(prdata), .apb_pready_out(pready), .apb_pslverr_out(pslverr),
        .prx_addr_in(prx_addr), .prx_wdata_in(prx_wdata), .prx_wr_in(prx_wr), .prx_rd_in(prx_rd),
        .prx_rdata_out(prx_rdata), .prx_rvld_out(prx_rvld), .ctr_cnt_in(ctr_cnt),
        .status_in(STATUS), .hw_version_in(HWVER), .hssl_stop_out(hssl_stop),
        .reply_key_out(reply_key), .input_wait_out(in_wait), .output_wait_out(out_wait),
        .rt_key_out(rt_key), .rt_mask_out(rt_mask), .rt_route_out(rt_route),
        .mp_key_out(mp_key), .mp_fmsk_out(mp_fmsk), .mp_fsft_out(mp_fsft), .ctr_out(ctr_o)
    );

    int          n_checks = 0, n_errors = 0, cyc = 0;
    exp_t        apb_q[$], prx_q[$];
    logic [31:0] mdl [0:255];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register map: which locations exist, and how a stored word reads back.
    function automatic logic loc_valid(input logic [3:0] s, input logic [3:0] r);
        case (s)
            4'd0:                return (r <= 4'd4) || (r >= 4'd14);
            4'd1, 4'd2, 4'd3, 4'd5: return r < 4'd4;
            4'd4:                return r < 4'd8;
            4'd6, 4'd7:          return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] norm(input logic [3:0] s, input logic [3:0] r, input logic [31:0] v);
        if (s == 4'd0 && r == 4'd0) return v & 32'h3;
        if (s == 4'd3) return v & 32'h7;
        if (s == 4'd7) return v[5] ? (v | 32'hffff_ffc0) : (v & 32'h3f);
        return v;
    endfunction

    function automatic logic [31:0] mread(input logic [3:0] s, input logic [3:0] r);
        if (!loc_valid(s, r)) return BAD;
        if (s == 4'd0 && r == 4'd14) return STATUS;
        if (s == 4'd0 && r == 4'd15) return HWVER;
        return mdl[{s, r}];
    endfunction

    task automatic mdl_prx_write(input logic [7:0] a, input logic [31:0] d);
        if (loc_valid(a[7:4], a[3:0]) && !(a[7:4] == 4'd0 && a[3:0] >= 4'd14))
            mdl[a] = norm(a[7:4], a[3:0], d);
    endtask

    task automatic apb_xfer(input logic wr, input logic [9:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int extra);
        exp_t e;
        int c0;
        logic [3:0] s, r;
        logic [31:0] old, mrg;
        bit got;
        s = addr[9:6];
        r = addr[5:2];
        @(posedge clk); #1;
        c0 = cyc;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        if (extra > 0) begin
            prx_addr = {s, r};
            prx_wr = 1'b1;
            for (int k = 0; k < extra; k++) begin
                prx_wdata = $urandom();
                mdl_prx_write({s, r}, prx_wdata);
                @(posedge clk); #1;
            end
            prx_wr = 1'b0;
        end
        e.err = !loc_valid(s, r) || (wr && s == 4'd0 && r >= 4'd14);
        old = mread(s, r);
        e.data = old;
        e.chk_data = !wr;
        e.cyc = c0 + 2 + extra;
        for (int b = 0; b < 4; b++) mrg[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
        if (wr && !e.err) mdl[{s, r}] = norm(s, r, mrg);
        if (!wr && !e.err && s == 4'd4 && mdl[8'h00][1]) mdl[{s, r}] = 32'h0;
        apb_q.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pready === 1'b1) begin got = 1'b1; break; end
        end
        if (!got) check("apb_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic prx_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        prx_addr = a; prx_wdata = d; prx_wr = 1'b1;
        mdl_prx_write(a, d);
        @(posedge clk); #1;
        prx_wr = 1'b0;
    endtask

    task automatic prx_read(input logic [7:0] a);
        exp_t e;
        @(posedge clk); #1;
        prx_addr = a; prx_rd = 1'b1;
        e.data = mread(a[7:4], a[3:0]); e.err = 1'b0; e.chk_data = 1'b1; e.cyc = cyc + 1;
        prx_q.push_back(e);
        @(posedge clk); #1;
        prx_rd = 1'b0;
    endtask

    task automatic ctr_pulse(input int idx, input int n);
        @(posedge clk); #1;
        ctr_cnt[idx] = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (mdl[{4'd4, 4'(idx)}] != 32'hffff_ffff) mdl[{4'd4, 4'(idx)}] += 32'd1;
            @(posedge clk); #1;
        end
        ctr_cnt[idx] = 1'b0;
    endtask

    // Monitor: every response the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && pready === 1'b1) begin
            if (apb_q.size() == 0) check("apb_spurious_pready", 32'd1, 32'd0);
            else begin
                e = apb_q.pop_front();
                check("apb_pready_cycle", 32'(cyc), 32'(e.cyc));
                check("apb_pslverr", {31'd0, pslverr}, {31'd0, e.err});
                if (e.chk_data) check("apb_prdata", prdata, e.data);
            end
        end
        if (!reset && prx_rvld === 1'b1) begin
            if (prx_q.size() == 0) check("prx_spurious_rvld", 32'd1, 32'd0);
            else begin
                e = prx_q.pop_front();
                check("prx_rvld_cycle", 32'(cyc), 32'(e.cyc));
                check("prx_rdata", prx_rdata, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0] s, r;
        for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
        mdl[8'h01] = BAD; mdl[8'h02] = 32'hffff_fd00; mdl[8'h03] = 32'd32; mdl[8'h04] = 32'd32;
        for (int i = 0; i < 16; i++) mdl[{4'd1, 4'(i)}] = 32'hffff_ffff;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_pready", {31'd0, pready}, 32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_prx_rvld", {31'd0, prx_rvld}, 32'd0);
        check("rst_prx_rdata", prx_rdata, 32'd0);
        check("rst_reply_key", reply_key, 32'hffff_fd00);
        check("rst_in_wait", in_wait, 32'd32);
        check("rst_rt_key0", rt_key[31:0], 32'hffff_ffff);

        apb_xfer(1'b0, 10'h040, 32'h0, 4'h0, 0);
        apb_xfer(1'b0, 10'h00c, 32'h0, 4'h0, 0);
        apb_xfer(1'b0, 10'h038, 32'h0, 4'h0, 0);
        apb_xfer(1'b1, 10'h008, 32'h1234_5678, 4'b0011, 0);
        apb_xfer(1'b0, 10'h008, 32'h0, 4'h0, 0);
        check("reply_key_strb", reply_key, 32'hffff_5678);
        apb_xfer(1'b1, 10'h00c, 32'hcafe_0001, 4'hf, 3);
        apb_xfer(1'b0, 10'h00c, 32'h0, 4'h0, 0);
        check("in_wait_after_pw", in_wait, 32'hcafe_0001);

        apb_xfer(1'b1, 10'h03c, 32'h1111_1111, 4'hf, 0);
        apb_xfer(1'b0, 10'h03c, 32'h0, 4'h0, 0);
        apb_xfer(1'b0, 10'h200, 32'h0, 4'h0, 0);
        apb_xfer(1'b1, 10'h05c, 32'h2222_2222, 4'hf, 0);
        apb_xfer(1'b0, 10'h05c, 32'h0, 4'h0, 0);

        prx_write(8'h40, 32'hffff_fffe);
        ctr_pulse(0, 3);
        check("ctr0_saturated", ctr_o[31:0], 32'hffff_ffff);
        apb_xfer(1'b0, 10'h100, 32'h0, 4'h0, 0);
        apb_xfer(1'b1, 10'h000, 32'h2, 4'hf, 0);
        apb_xfer(1'b0, 10'h100, 32'h0, 4'h0, 0);
        apb_xfer(1'b0, 10'h100, 32'h0, 4'h0, 0);
        apb_xfer(1'b1, 10'h000, 32'h0, 4'hf, 0);

        prx_write(8'h70, 32'h0000_003f);
        prx_read(8'h70);
        prx_read(8'h90);
        @(posedge clk); #1;
        prx_addr = 8'h71; prx_wdata = 32'h0000_0015; prx_wr = 1'b1; prx_rd = 1'b1;
        mdl_prx_write(8'h71, 32'h0000_0015);
        @(posedge clk); #1;
        prx_wr = 1'b0; prx_rd = 1'b0;
        @(negedge clk);
        check("prx_rdwr_no_rvld", {31'd0, prx_rvld}, 32'd0);

        for (int n = 0; n < 200; n++) begin
            s = 4'($urandom_range(0, 9));
            r = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: apb_xfer(1'b0, {s, r, 2'b00}, 32'h0, 4'h0, 0);
                1: apb_xfer(1'b1, {s, r, 2'b00}, $urandom(), 4'($urandom_range(0, 15)), 0);
                2: prx_write({s, r}, $urandom());
                default: prx_read({s, r});
            endcase
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("apb_q_drained", 32'(apb_q.size()), 32'd0);
        check("prx_q_drained", 32'(prx_q.size()), 32'd0);
        check("hssl_stop", {31'd0, hssl_stop}, mdl[8'h00] & 32'h1);
        check("reply_key", reply_key, mdl[8'h02]);
        check("in_wait", in_wait, mdl[8'h03]);
        check("out_wait", out_wait, mdl[8'h04]);
        for (int i = 0; i < NR; i++) begin
            check("rt_key", rt_key[32*i +: 32], mdl[{4'd1, 4'(i)}]);
            check("rt_mask", rt_mask[32*i +: 32], mdl[{4'd2, 4'(i)}]);
            check("rt_route", {29'd0, rt_route[3*i +: 3]}, mdl[{4'd3, 4'(i)}]);
            check("mp_key", mp_key[32*i +: 32], mdl[{4'd5, 4'(i)}]);
        end
        for (int i = 0; i < 8; i++) check("ctr", ctr_o[32*i +: 32], mdl[{4'd4, 4'(i)}]);
        for (int i = 0; i < 16; i++) begin
            check("mp_fmsk", mp_fmsk[32*i +: 32], mdl[{4'd6, 4'(i)}]);
            check("mp_fsft", {26'd0, mp_fsft[6*i +: 6]}, mdl[{4'd7, 4'(i)}] & 32'h3f);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
